// File: rtl/qspi_cmd_ctrl.sv
// QSPI command controller: decodes WRITE/READ/AUDIO commands and owns QD direction for read-back.
// Define QSPI_CTRL_AUTOINC_EN to auto-increment the register address after each write/transmit load.
module qspi_cmd_ctrl #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          qss,
  input  logic          rx_ready,
  input  logic [7:0]    rx_data,
  input  logic          tx_ready,
  output logic [7:0]    tx_data,
  output logic          qd_oe,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          sample_valid,
  output logic [7:0]    sample_data,
  output logic          cmd_err
);

  localparam logic [2:0] S_CMD     = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_WDATA   = 3'd2;
  localparam logic [2:0] S_RADDR   = 3'd3;
  localparam logic [2:0] S_AUDIO   = 3'd4;
  localparam logic [2:0] S_DISCARD = 3'd5;
  localparam logic [2:0] S_TX      = 3'd6;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_AUDIO = 8'h10;

`ifdef QSPI_CTRL_AUTOINC_EN
  localparam logic [AW-1:0] ADDR_STEP = AW'(1);
`else
  localparam logic [AW-1:0] ADDR_STEP = '0;
`endif

  logic [2:0]    r_qss_sync;
  logic [2:0]    r_state;
  logic          r_armed;
  logic          r_tx_pend;
  logic [AW-1:0] r_addr;

  logic          w_deselect;
  logic [2:0]    w_state_nxt;
  logic          w_armed_nxt;
  logic          w_pend_nxt;
  logic [AW-1:0] w_addr_nxt;
  logic          w_oe_nxt;
  logic          w_raddr_byte;
  logic          w_wr;
  logic          w_smp;
  logic          w_err;
  logic          w_load;

  // Idle level is deselected, so the chain resets high to avoid a false deselect after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qss_sync <= 3'b111;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_qss_sync <= {r_qss_sync[1:0], qss};
    end
  end

  assign w_deselect = r_qss_sync[1] & ~r_qss_sync[2];
  assign rd_addr    = r_addr;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch can be inferred.
    w_state_nxt  = r_state;
    w_armed_nxt  = r_armed;
    w_pend_nxt   = 1'b0;
    w_addr_nxt   = r_addr;
    w_oe_nxt     = qd_oe;
    w_raddr_byte = 1'b0;
    w_wr         = 1'b0;
    w_smp        = 1'b0;
    w_err        = 1'b0;
    w_load       = 1'b0;

    // Byte phase: a received byte is consumed in the current state first.
    if (rx_ready && (r_state != S_TX)) begin
      case (r_state)
        S_CMD: begin
          case (rx_data)
            CMD_WRITE: w_state_nxt = S_ADDR;
            CMD_READ: begin
              w_state_nxt = S_RADDR;
              w_armed_nxt = 1'b0;
            end
            CMD_AUDIO: w_state_nxt = S_AUDIO;
            default: begin
              w_err       = 1'b1;
              w_state_nxt = S_DISCARD;
            end
          endcase
        end
        S_ADDR: begin
          w_addr_nxt  = rx_data[AW-1:0];
          w_state_nxt = S_WDATA;
        end
        S_WDATA: begin
          w_wr       = 1'b1;
          w_addr_nxt = r_addr + ADDR_STEP;
        end
        S_RADDR: begin
          if (!r_armed) begin
            w_addr_nxt   = rx_data[AW-1:0];
            w_armed_nxt  = 1'b1;
            w_raddr_byte = 1'b1;
          end
        end
        S_AUDIO: w_smp = 1'b1;
        default: ;
      endcase
    end

    // Transmit phase: a deferred first load, or a refill on each consumed byte.
    if (r_state == S_TX) begin
      if (r_tx_pend) begin
        w_load     = 1'b1;
        w_addr_nxt = r_addr + ADDR_STEP;
        w_oe_nxt   = 1'b1;
      end else if (tx_ready) begin
        w_load     = 1'b1;
        w_addr_nxt = r_addr + ADDR_STEP;
      end
    end

    // Deselect acts on the state that results from the byte phase.
    if (w_deselect) begin
      w_armed_nxt = 1'b0;
      if (r_state == S_TX) begin
        w_oe_nxt    = 1'b0;
        w_state_nxt = S_CMD;
      end else if ((w_state_nxt == S_RADDR) && (w_raddr_byte || r_armed)) begin
        w_state_nxt = S_TX;
        if (w_raddr_byte) begin
          // rd_data still reflects the old address this cycle; load from the new one next cycle.
          w_pend_nxt = 1'b1;
        end else begin
          w_load     = 1'b1;
          w_addr_nxt = r_addr + ADDR_STEP;
          w_oe_nxt   = 1'b1;
        end
      end else if (w_state_nxt == S_RADDR) begin
        w_err       = 1'b1;
        w_state_nxt = S_CMD;
      end else begin
        w_state_nxt = S_CMD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CMD;
      r_armed   <= 1'b0;
      r_tx_pend <= 1'b0;
      r_addr    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_armed   <= w_armed_nxt;
      r_tx_pend <= w_pend_nxt;
      r_addr    <= w_addr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data      <= 8'h00;
      qd_oe        <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 8'h00;
      sample_valid <= 1'b0;
      sample_data  <= 8'h00;
      cmd_err      <= 1'b0;
    end else begin
      qd_oe        <= w_oe_nxt;
      wr_en        <= w_wr;
      sample_valid <= w_smp;
      cmd_err      <= w_err;
      if (w_load) tx_data <= rd_data;
      if (w_wr) begin
        wr_addr <= r_addr;
        wr_data <= rx_data;
      end
      if (w_smp) sample_data <= rx_data;
    end
  end

endmodule

// File: tb/tb_qspi_cmd_ctrl.sv
// Self-checking bench for qspi_cmd_ctrl: directed test-plan steps plus random transactions
// checked against a transaction-level model of the command protocol.
module tb_qspi_cmd_ctrl;

  localparam int AW   = 4;
  localparam int NREG = 1 << AW;
`ifdef QSPI_CTRL_AUTOINC_EN
  localparam int STEP = 1;
`else
  localparam int STEP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          qss;
  logic          rx_ready;
  logic [7:0]    rx_data;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic          qd_oe;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          sample_valid;
  logic [7:0]    sample_data;
  logic          cmd_err;

  logic [7:0] regs [NREG];
  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;

  qspi_cmd_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .qss(qss),
    .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_data(tx_data), .qd_oe(qd_oe),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .cmd_err(cmd_err)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  wr_t        wr_log[$];
  logic [7:0] smp_log[$];
  int         err_cnt = 0;
  int         oe_cycles = 0;
  int         tests = 0;
  int         fails = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) wr_log.push_back({wr_addr, wr_data});
      if (sample_valid) smp_log.push_back(sample_data);
      if (cmd_err) err_cnt++;
      if (qd_oe) oe_cycles++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(2);
  endtask

  task automatic tx_pulse();
    tx_ready = 1'b1;
    step(1);
    tx_ready = 1'b0;
    step(2);
  endtask

  task automatic select_bus();
    qss = 1'b0;
    step(4);
  endtask

  task automatic deselect_bus();
    qss = 1'b1;
    step(6);
  endtask

  // One receive transaction, plus read-back of n_tx extra bytes when it is an armed READ.
  task automatic run_txn(input logic [7:0] b[$], input int n_tx, input string tag);
    int  wr0, s0, e0, o0, a, n;
    int  exp_err;
    bit  is_read;
    wr_t exp_wr[$];
    logic [7:0] exp_smp[$];

    wr0 = wr_log.size();
    s0  = smp_log.size();
    e0  = err_cnt;
    o0  = oe_cycles;
    n   = b.size();
    exp_err = 0;
    is_read = 1'b0;
    a = 0;

    case (b[0])
      8'h01: if (n >= 2) begin
        a = int'(b[1]) % NREG;
        for (int i = 2; i < n; i++) begin
          exp_wr.push_back({a[AW-1:0], b[i]});
          a = (a + STEP) % NREG;
        end
      end
      8'h0B: if (n >= 2) begin
        is_read = 1'b1;
        a = int'(b[1]) % NREG;
      end else exp_err = 1;
      8'h10: for (int i = 1; i < n; i++) exp_smp.push_back(b[i]);
      default: exp_err = 1;
    endcase

    select_bus();
    foreach (b[i]) send_byte(b[i]);
    deselect_bus();

    if (is_read) begin
      chk({tag, ".oe_on"}, qd_oe, 1);
      chk({tag, ".tx0"}, tx_data, regs[a]);
      select_bus();
      for (int k = 1; k <= n_tx; k++) begin
        tx_pulse();
        chk({tag, ".txk"}, tx_data, regs[(a + k * STEP) % NREG]);
      end
      deselect_bus();
      chk({tag, ".oe_off"}, qd_oe, 0);
    end else begin
      chk({tag, ".oe_quiet"}, oe_cycles - o0, 0);
    end

    chk({tag, ".n_wr"}, wr_log.size() - wr0, exp_wr.size());
    for (int i = 0; i < exp_wr.size(); i++)
      if (wr0 + i < wr_log.size()) chk({tag, ".wr"}, wr_log[wr0 + i], exp_wr[i]);
    chk({tag, ".n_smp"}, smp_log.size() - s0, exp_smp.size());
    for (int i = 0; i < exp_smp.size(); i++)
      if (s0 + i < smp_log.size()) chk({tag, ".smp"}, smp_log[s0 + i], exp_smp[i]);
    chk({tag, ".err"}, err_cnt - e0, exp_err);

    // The register file follows whatever the design actually wrote.
    for (int i = wr0; i < wr_log.size(); i++) regs[wr_log[i].a] = wr_log[i].d;
  endtask

  initial begin
    logic [7:0] q[$];
    int e0, len, pick;
    logic [7:0] c;

    for (int i = 0; i < NREG; i++) regs[i] = 8'($urandom);
    rst_n = 1'b0; qss = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    step(2);
    chk("rst.tx_data", tx_data, 8'h00);
    chk("rst.qd_oe", qd_oe, 0);
    chk("rst.wr_en", wr_en, 0);
    chk("rst.wr_addr", wr_addr, 0);
    chk("rst.wr_data", wr_data, 0);
    chk("rst.sample_valid", sample_valid, 0);
    chk("rst.sample_data", sample_data, 0);
    chk("rst.cmd_err", cmd_err, 0);
    chk("rst.rd_addr", rd_addr, 0);
    rst_n = 1'b1;
    step(2);

    q = '{8'h01, 8'h03, 8'hAA, 8'h55};  run_txn(q, 0, "write");
    regs[5] = 8'h12; regs[6] = 8'h34;
    q = '{8'h0B, 8'h05};                run_txn(q, 1, "read");
    q = '{8'h10, 8'h80, 8'h7F};         run_txn(q, 0, "audio");
    q = '{8'hFF, 8'h01};                run_txn(q, 0, "bad_cmd");
    q = '{8'h0B};                       run_txn(q, 0, "read_noaddr");
    q = '{8'h01, 8'h0F, 8'hA1, 8'hB2};  run_txn(q, 0, "wrap");

    // Address byte coincident with the deselect pulse (3 clk after the qss rise).
    e0 = err_cnt;
    select_bus();
    send_byte(8'h0B);
    qss = 1'b1;
    step(2);
    rx_data = 8'h09; rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(4);
    chk("coinc.oe_on", qd_oe, 1);
    chk("coinc.tx0", tx_data, regs[9]);
    chk("coinc.err", err_cnt - e0, 0);
    select_bus();
    tx_pulse();
    chk("coinc.tx1", tx_data, regs[(9 + STEP) % NREG]);
    deselect_bus();
    chk("coinc.oe_off", qd_oe, 0);

    for (int t = 0; t < 40; t++) begin
      q.delete();
      pick = $urandom_range(0, 3);
      case (pick)
        0: c = 8'h01;
        1: c = 8'h0B;
        2: c = 8'h10;
        default: begin
          c = 8'($urandom);
          while (c == 8'h01 || c == 8'h0B || c == 8'h10) c = 8'($urandom);
        end
      endcase
      q.push_back(c);
      len = $urandom_range(0, 5);
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      run_txn(q, $urandom_range(0, 3), "rand");
    end

    // Reset while transmitting releases QD immediately.
    select_bus();
    send_byte(8'h0B);
    send_byte(8'h02);
    deselect_bus();
    chk("rst_tx.oe_before", qd_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx.oe", qd_oe, 0);
    chk("rst_tx.tx_data", tx_data, 8'h00);
    chk("rst_tx.rd_addr", rd_addr, 0);
    step(1);
    rst_n = 1'b1;
    step(2);
    q = '{8'h01, 8'h07, 8'h9C};         run_txn(q, 0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/qspi_cmd_ctrl.md
# qspi_cmd_ctrl

Byte-level command controller between the QSPI slave byte receiver/transmitter and the rest of the FPGA. It decodes the first byte of each QSPI transaction as a command, sequences address and data bytes into an external register file or the audio sample stream, and schedules read-back by owning the QD tri-state direction across transactions. It replaces the ad-hoc read/write toggle at the top level.

## Interface
Parameters:
- AW, 4, register address width; register space is 2^AW bytes

Ports:
- clk  in  1  system clock (CLK100 domain)
- rst_n  in  1  asynchronous active-low reset
- qss  in  1  raw QSPI slave select (high = deselected), asynchronous
- rx_ready  in  1  one-cycle strobe: rx_data holds a new received byte
- rx_data  in  8  received byte
- tx_ready  in  1  one-cycle strobe: transmitter consumed tx_data, next byte needed
- tx_data  out  8  byte to transmit
- qd_oe  out  1  1 = slave drives QD (transmit transaction)
- rd_addr  out  AW  register read address
- rd_data  in  8  register read data, combinational from rd_addr
- wr_en  out  1  one-cycle register write strobe
- wr_addr  out  AW  register write address
- wr_data  out  8  register write data
- sample_valid  out  1  one-cycle audio sample strobe
- sample_data  out  8  audio sample
- cmd_err  out  1  one-cycle strobe on protocol error

## Operation
- qss synchronised through 3 flops; deselect = synchronised qss rising edge (one-cycle pulse).
- Commands (first byte of a receive transaction): 0x01 WRITE, 0x0B READ, 0x10 AUDIO; any other value is an error.
- States: CMD, ADDR, WDATA, RADDR, AUDIO, DISCARD, TX.
- CMD: rx byte 0x01 -> ADDR; 0x0B -> RADDR; 0x10 -> AUDIO; other -> cmd_err pulse, DISCARD.
- ADDR: rx byte [AW-1:0] loads addr; -> WDATA.
- WDATA: each rx byte -> wr_en, wr_addr = addr, wr_data = byte; addr increments (see Configuration).
- RADDR: rx byte loads addr; stays in RADDR with flag rd_armed = 1; further bytes ignored.
- AUDIO: each rx byte -> sample_valid, sample_data = byte.
- DISCARD: bytes ignored.
- deselect in RADDR with rd_armed = 1: tx_data <= rd_data at rd_addr = addr, addr increments, qd_oe <= 1, -> TX.
- deselect in RADDR with rd_armed = 0: cmd_err pulse, -> CMD, qd_oe stays 0.
- deselect in any other receive state: -> CMD.
- TX: on tx_ready, tx_data <= rd_data at rd_addr = addr, addr increments; rx_ready ignored. deselect -> qd_oe <= 0, -> CMD.
- rd_addr always equals addr.
- Address arithmetic is modulo 2^AW; wraps 2^AW-1 -> 0 silently.

## Timing
- Reset values: tx_data = 0x00, qd_oe = 0, wr_en = 0, wr_addr = 0, wr_data = 0, sample_valid = 0, sample_data = 0, cmd_err = 0, rd_addr = 0, state CMD.
- wr_en and sample_valid are asserted the cycle after rx_ready (registered outputs).
- tx_data updates the cycle after tx_ready, well before the next QCK rising edge.
- deselect occurs 3 clk after the qss rise; qd_oe changes the cycle after deselect.
- rx_ready and deselect in the same cycle: the byte is processed in the current state first, then the deselect transition applies. A READ address byte arriving with deselect arms and enters TX.
- rst_n low mid-transaction: all outputs return to reset values immediately and qd_oe releases QD at once. The next transaction starts in CMD.

## Configuration
- QSPI_CTRL_AUTOINC_EN defined: addr increments after every WDATA write and every TX load, as described above.
- Undefined: addr holds. Repeated writes hit the same register, and repeated reads return the same register.

## Test plan
- WRITE: tx 0x01,0x03,0xAA,0x55 then deselect -> wr_en twice: (3,0xAA), (4,0x55); qd_oe stays 0.
- READ: regs[5]=0x12, regs[6]=0x34; tx 0x0B,0x05, deselect -> qd_oe=1, tx_data=0x12; tx_ready -> tx_data=0x34; deselect -> qd_oe=0.
- AUDIO: 0x10,0x80,0x7F -> two sample_valid pulses with 0x80, 0x7F; no wr_en.
- Errors: 0xFF,0x01 -> cmd_err once, no writes. 0x0B then deselect -> cmd_err, qd_oe stays 0.
- Wrap and simultaneity: AW=4, WRITE at addr 0xF with two bytes -> writes to 0xF then 0x0. Address byte with rx_ready coincident with deselect -> TX entered.
- Reset: assert rst_n during TX -> qd_oe=0 same cycle, state CMD. Repeat with QSPI_CTRL_AUTOINC_EN undefined -> READ returns the same register twice.
